// File: rtl/rca_lsq_arbiter_pkg.sv
// Shared types and defaults for the RCA grid-slot to LSQ arbiter.
//   NUM_GRID_SLOTS             default number of grid slots with an LSQ port
//   XLEN                       address/data width
//   MAX_OUTSTANDING_LOADS_DFLT default depth of the in-order load-tag FIFO
//   slot_id_t                  slot index for the default slot count
//   lsq_req_t                  one buffered load/store request
//   id_width()                 index width for n entries, never below 1 bit
package rca_lsq_arbiter_pkg;

   localparam int NUM_GRID_SLOTS             = 4;
   localparam int XLEN                       = 32;
   localparam int MAX_OUTSTANDING_LOADS_DFLT = 8;
   localparam int SLOT_ID_W                  = $clog2(NUM_GRID_SLOTS);

   typedef logic [SLOT_ID_W-1:0] slot_id_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [2:0]      fn3;
      logic            load;
      logic            store;
   } lsq_req_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rca_lsq_arbiter_if.sv
// Bus bundle between the grid slots, the arbiter and the LSQ port.
//   slot_* inputs      per-slot request fields and single-cycle strobe
//   slot_* outputs     per-slot backpressure, load return data and pulse
//   lsq_* outputs      request issued towards the LSQ
//   lsq_* inputs       LSQ backpressure and in-order load completion
// Modports:
//   slave   the arbiter (serves slot requests, issues to the LSQ)
//   master  the surrounding environment (slots plus LSQ)
interface rca_lsq_arbiter_if
   import rca_lsq_arbiter_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_GRID_SLOTS
);

   logic [NUM_SLOTS-1:0][XLEN-1:0] slot_addr;
   logic [NUM_SLOTS-1:0][XLEN-1:0] slot_data;
   logic [NUM_SLOTS-1:0][2:0]      slot_fn3;
   logic [NUM_SLOTS-1:0]           slot_load;
   logic [NUM_SLOTS-1:0]           slot_store;
   logic [NUM_SLOTS-1:0]           slot_new_request;
   logic [NUM_SLOTS-1:0]           slot_lsq_full;
   logic [NUM_SLOTS-1:0][XLEN-1:0] slot_load_data;
   logic [NUM_SLOTS-1:0]           slot_load_complete;

   logic [XLEN-1:0]                lsq_addr;
   logic [XLEN-1:0]                lsq_data;
   logic [2:0]                     lsq_fn3;
   logic                           lsq_load;
   logic                           lsq_store;
   logic                           lsq_new_request;
   logic                           lsq_full;
   logic [XLEN-1:0]                lsq_load_data;
   logic                           lsq_load_complete;

   modport slave (
      input  slot_addr, slot_data, slot_fn3, slot_load, slot_store, slot_new_request,
      input  lsq_full, lsq_load_data, lsq_load_complete,
      output slot_lsq_full, slot_load_data, slot_load_complete,
      output lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_new_request
   );

   modport master (
      output slot_addr, slot_data, slot_fn3, slot_load, slot_store, slot_new_request,
      output lsq_full, lsq_load_data, lsq_load_complete,
      input  slot_lsq_full, slot_load_data, slot_load_complete,
      input  lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_new_request
   );

endinterface

// File: rtl/rca_lsq_arbiter_rr.sv
// Round-robin single-grant arbiter with its own rotating pointer.
//   clk, rst      clock, synchronous active-high reset (pointer -> 0)
//   req_i         request vector
//   grant_o       one-hot grant, first request at or after the pointer
//   grant_idx_o   index of the granted request
//   grant_any_o   a grant was made this cycle
// The pointer moves to granted index + 1 (mod N) and holds when idle.
module rca_rr_arbiter
   import rca_lsq_arbiter_pkg::*;
#(
   parameter int N = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             req_i,
   output logic [N-1:0]             grant_o,
   output logic [id_width(N)-1:0]   grant_idx_o,
   output logic                     grant_any_o
);

   localparam int IW = id_width(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx_c;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      idx_c       = '0;
      for (int k = 0; k < N; k++) begin
         idx_c = IW'((int'(ptr_q) + k) % N);
         if (!grant_any_o && req_i[idx_c]) begin
            grant_any_o    = 1'b1;
            grant_o[idx_c] = 1'b1;
            grant_idx_o    = idx_c;
         end
      end
      ptr_d = ptr_q;
      if (grant_any_o) begin
         ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rca_lsq_arbiter.sv
// Arbiter between the RCA grid slots' LSQ request ports and the single
// Taiga load/store queue port.
//   clk, rst       clock, synchronous active-high reset
//   bus (slave)    slot request/return signals and the LSQ port
//   stall_cycles   (only with RCA_LSQ_ARB_PERF_EN) saturating count of
//                  cycles with a pending hold but no issue
// Each slot has a one-entry hold register; pending holds are issued one
// per cycle in round-robin order. Issued loads leave their slot ID in an
// in-order tag FIFO so each LSQ load completion is routed back, one cycle
// later, to the slot that asked for it.
// Optional feature macro: RCA_LSQ_ARB_PERF_EN.
module rca_lsq_arbiter
   import rca_lsq_arbiter_pkg::*;
#(
   parameter int NUM_SLOTS             = NUM_GRID_SLOTS,
   parameter int MAX_OUTSTANDING_LOADS = MAX_OUTSTANDING_LOADS_DFLT
)(
   input  logic              clk,
   input  logic              rst,
   rca_lsq_arbiter_if.slave  bus
`ifdef RCA_LSQ_ARB_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int SW = id_width(NUM_SLOTS);
   localparam int TW = id_width(MAX_OUTSTANDING_LOADS);
   localparam int CW = TW + 1;

   typedef logic [SW-1:0] tag_t;

   // slot hold registers
   lsq_req_t             hold_q [NUM_SLOTS];
   lsq_req_t             hold_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] hold_valid_q, hold_valid_d;

   logic [NUM_SLOTS-1:0] eligible;
   logic [NUM_SLOTS-1:0] grant;
   logic [NUM_SLOTS-1:0] slot_full;
   logic [SW-1:0]        grant_idx;
   logic                 grant_any;
   lsq_req_t             issue_req;

   // in-order load-tag FIFO
   tag_t                 tag_mem_q [MAX_OUTSTANDING_LOADS];
   tag_t                 tag_mem_d [MAX_OUTSTANDING_LOADS];
   logic [TW-1:0]        tag_rd_q, tag_rd_d;
   logic [TW-1:0]        tag_wr_q, tag_wr_d;
   logic [CW-1:0]        tag_cnt_q, tag_cnt_d;
   logic                 tag_full, tag_empty, tag_push, tag_pop;
   tag_t                 tag_head;

   // load return
   logic [NUM_SLOTS-1:0]           complete_q, complete_d;
   logic [NUM_SLOTS-1:0][XLEN-1:0] load_data_q, load_data_d;

   assign tag_full  = (tag_cnt_q == CW'(MAX_OUTSTANDING_LOADS));
   assign tag_empty = (tag_cnt_q == '0);
   assign tag_head  = tag_mem_q[tag_rd_q];

   // The load check uses this cycle's FIFO count only; a pop happening in
   // the same cycle does not open a slot until the next cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         eligible[i] = hold_valid_q[i] && !bus.lsq_full && (!hold_q[i].load || !tag_full);
      end
   end

   rca_rr_arbiter #(
      .N (NUM_SLOTS)
   ) u_rr (
      .clk         (clk),
      .rst         (rst),
      .req_i       (eligible),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_any_o (grant_any)
   );

   // A granted hold frees up in the same cycle, so a slot may strobe again
   // right away and keep one request per cycle flowing.
   assign slot_full = hold_valid_q & ~grant;
   assign issue_req = hold_q[grant_idx];

   assign bus.slot_lsq_full      = slot_full;
   assign bus.lsq_new_request    = grant_any;
   assign bus.lsq_addr           = issue_req.addr;
   assign bus.lsq_data           = issue_req.data;
   assign bus.lsq_fn3            = issue_req.fn3;
   assign bus.lsq_load           = grant_any & issue_req.load;
   assign bus.lsq_store          = grant_any & issue_req.store;
   assign bus.slot_load_complete = complete_q;
   assign bus.slot_load_data     = load_data_q;

   // Strobes against a full slot are dropped; capture wins over release.
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (grant[i]) begin
            hold_valid_d[i] = 1'b0;
         end
         if (bus.slot_new_request[i] && !slot_full[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_d[i]       = '{addr:  bus.slot_addr[i],
                                data:  bus.slot_data[i],
                                fn3:   bus.slot_fn3[i],
                                load:  bus.slot_load[i],
                                store: bus.slot_store[i]};
         end
      end
   end

   assign tag_push = grant_any && issue_req.load;
   assign tag_pop  = bus.lsq_load_complete && !tag_empty;

   always_comb begin
      tag_mem_d = tag_mem_q;
      tag_wr_d  = tag_wr_q;
      tag_rd_d  = tag_rd_q;
      tag_cnt_d = tag_cnt_q;
      if (tag_push) begin
         tag_mem_d[tag_wr_q] = grant_idx;
         tag_wr_d            = tag_wr_q + 1'b1;
      end
      if (tag_pop) begin
         tag_rd_d = tag_rd_q + 1'b1;
      end
      case ({tag_push, tag_pop})
         2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
         2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
         default: tag_cnt_d = tag_cnt_q;
      endcase
   end

   // Completions with no tag outstanding are dropped silently.
   always_comb begin
      complete_d  = '0;
      load_data_d = load_data_q;
      if (tag_pop) begin
         complete_d[tag_head]  = 1'b1;
         load_data_d[tag_head] = bus.lsq_load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            hold_q[i] <= '0;
         end
         for (int j = 0; j < MAX_OUTSTANDING_LOADS; j++) begin
            tag_mem_q[j] <= '0;
         end
         hold_valid_q <= '0;
         tag_rd_q     <= '0;
         tag_wr_q     <= '0;
         tag_cnt_q    <= '0;
         complete_q   <= '0;
         load_data_q  <= '0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tag_mem_q    <= tag_mem_d;
         tag_rd_q     <= tag_rd_d;
         tag_wr_q     <= tag_wr_d;
         tag_cnt_q    <= tag_cnt_d;
         complete_q   <= complete_d;
         load_data_q  <= load_data_d;
      end
   end

`ifdef RCA_LSQ_ARB_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((|hold_valid_q) && !grant_any && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Bench for rca_lsq_arbiter: directed slot/LSQ traffic, a queue-based
// reference model compared on every cycle, plus literal spot checks.
module tb_rca_lsq_arbiter;

   localparam int N  = 4;
   localparam int ML = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rca_lsq_arbiter_if #(.NUM_SLOTS(N)) bus ();

`ifdef RCA_LSQ_ARB_PERF_EN
   logic [31:0] stall_cycles;
`endif

   rca_lsq_arbiter #(
      .NUM_SLOTS             (N),
      .MAX_OUTSTANDING_LOADS (ML)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef RCA_LSQ_ARB_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_valid [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_data  [N];
   logic [2:0]  m_fn3   [N];
   logic        m_load  [N];
   logic        m_store [N];
   logic [31:0] m_ret   [N];
   int          m_ptr;
   int          m_tags [$];
   int          m_pulse;
   logic [31:0] m_stall;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_ret[i]   = '0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
         m_fn3[i]   = '0;
         m_load[i]  = 1'b0;
         m_store[i] = 1'b0;
      end
      m_ptr   = 0;
      m_pulse = -1;
      m_stall = '0;
      m_tags.delete();
   endtask

   task automatic model_cycle();
      int         w;
      int         t;
      logic       any_valid;
      logic [N-1:0] exp_full;
      logic [N-1:0] exp_cmp;
      w = -1;
      for (int k = 0; k < N; k++) begin
         int s;
         s = (m_ptr + k) % N;
         if (w < 0 && m_valid[s] && !bus.lsq_full && (!m_load[s] || m_tags.size() < ML)) w = s;
      end
      exp_full  = '0;
      any_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp_full[i] = m_valid[i] && (i != w);
         any_valid   = any_valid | m_valid[i];
      end
      exp_cmp = '0;
      if (m_pulse >= 0) exp_cmp[m_pulse] = 1'b1;

      chk("mdl_slot_lsq_full", 64'(bus.slot_lsq_full), 64'(exp_full));
      chk("mdl_lsq_new_request", 64'(bus.lsq_new_request), 64'(w >= 0));
      if (w >= 0) begin
         chk("mdl_lsq_addr", 64'(bus.lsq_addr), 64'(m_addr[w]));
         chk("mdl_lsq_data", 64'(bus.lsq_data), 64'(m_data[w]));
         chk("mdl_lsq_fn3", 64'(bus.lsq_fn3), 64'(m_fn3[w]));
         chk("mdl_lsq_load", 64'(bus.lsq_load), 64'(m_load[w]));
         chk("mdl_lsq_store", 64'(bus.lsq_store), 64'(m_store[w]));
      end
      chk("mdl_slot_load_complete", 64'(bus.slot_load_complete), 64'(exp_cmp));
      for (int i = 0; i < N; i++) begin
         chk("mdl_slot_load_data", 64'(bus.slot_load_data[i]), 64'(m_ret[i]));
      end
`ifdef RCA_LSQ_ARB_PERF_EN
      chk("mdl_stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif

      if (rst) begin
         model_reset();
      end else begin
         if (any_valid && w < 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (w >= 0) begin
            m_valid[w] = 1'b0;
            m_ptr      = (w + 1) % N;
         end
         m_pulse = -1;
         if (bus.lsq_load_complete && m_tags.size() > 0) begin
            t        = m_tags.pop_front();
            m_pulse  = t;
            m_ret[t] = bus.lsq_load_data;
         end
         if (w >= 0 && m_load[w]) m_tags.push_back(w);
         for (int i = 0; i < N; i++) begin
            if (bus.slot_new_request[i] && !exp_full[i]) begin
               m_valid[i] = 1'b1;
               m_addr[i]  = bus.slot_addr[i];
               m_data[i]  = bus.slot_data[i];
               m_fn3[i]   = bus.slot_fn3[i];
               m_load[i]  = bus.slot_load[i];
               m_store[i] = bus.slot_store[i];
            end
         end
      end
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      forever begin
         @(negedge clk);
         model_cycle();
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      bus.slot_new_request  = '0;
      bus.lsq_load_complete = 1'b0;
   endtask

   task automatic peek();
      #2;
   endtask

   task automatic put(input int s, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic ld);
      bus.slot_addr[s]        = a;
      bus.slot_data[s]        = d;
      bus.slot_fn3[s]         = f;
      bus.slot_load[s]        = ld;
      bus.slot_store[s]       = !ld;
      bus.slot_new_request[s] = 1'b1;
   endtask

   initial begin
      rst                   = 1'b1;
      bus.slot_addr         = '0;
      bus.slot_data         = '0;
      bus.slot_fn3          = '0;
      bus.slot_load         = '0;
      bus.slot_store        = '0;
      bus.slot_new_request  = '0;
      bus.lsq_full          = 1'b0;
      bus.lsq_load_data     = '0;
      bus.lsq_load_complete = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      peek();
      chk("rst_slot_lsq_full", 64'(bus.slot_lsq_full), 64'h0);
      chk("rst_lsq_new_request", 64'(bus.lsq_new_request), 64'h0);
      chk("rst_slot_load_complete", 64'(bus.slot_load_complete), 64'h0);
      for (int i = 0; i < N; i++) chk("rst_slot_load_data", 64'(bus.slot_load_data[i]), 64'h0);
      rst = 1'b0;
      step();

      // single store from slot 2
      put(2, 32'h100, 32'hDEAD_BEEF, 3'd2, 1'b0);
      peek();
      chk("t1_no_same_cycle_issue", 64'(bus.lsq_new_request), 64'h0);
      chk("t1_full_at_strobe", 64'(bus.slot_lsq_full), 64'h0);
      step(); peek();
      chk("t1_issue", 64'(bus.lsq_new_request), 64'h1);
      chk("t1_store", 64'(bus.lsq_store), 64'h1);
      chk("t1_load", 64'(bus.lsq_load), 64'h0);
      chk("t1_addr", 64'(bus.lsq_addr), 64'h100);
      chk("t1_data", 64'(bus.lsq_data), 64'hDEAD_BEEF);
      chk("t1_fn3", 64'(bus.lsq_fn3), 64'h2);
      chk("t1_full2", 64'(bus.slot_lsq_full[2]), 64'h0);
      step(); peek();
      chk("t1_idle", 64'(bus.lsq_new_request), 64'h0);
      // slot 3 alone brings the pointer back to 0
      put(3, 32'h300, 32'h0, 3'd2, 1'b0);
      step(); peek();
      chk("t1_realign_addr", 64'(bus.lsq_addr), 64'h300);
      step();

      // three simultaneous strobes, pointer at 0
      put(0, 32'h1000, 32'hA0, 3'd2, 1'b0);
      put(1, 32'h1010, 32'hA1, 3'd2, 1'b0);
      put(3, 32'h1030, 32'hA3, 3'd2, 1'b0);
      step(); peek();
      chk("t2_g0_addr", 64'(bus.lsq_addr), 64'h1000);
      chk("t2_g0_full", 64'(bus.slot_lsq_full), 64'hA);
      step(); peek();
      chk("t2_g1_addr", 64'(bus.lsq_addr), 64'h1010);
      chk("t2_g1_full", 64'(bus.slot_lsq_full), 64'h8);
      step(); peek();
      chk("t2_g3_addr", 64'(bus.lsq_addr), 64'h1030);
      chk("t2_g3_full", 64'(bus.slot_lsq_full), 64'h0);
      step(); peek();
      chk("t2_idle", 64'(bus.lsq_new_request), 64'h0);
      // pointer must have wrapped to 0: slot 0 beats slot 3
      put(3, 32'h2030, 32'h0, 3'd2, 1'b0);
      put(0, 32'h2000, 32'h0, 3'd2, 1'b0);
      step(); peek();
      chk("t2_ptr_wrap_first", 64'(bus.lsq_addr), 64'h2000);
      step(); peek();
      chk("t2_ptr_wrap_second", 64'(bus.lsq_addr), 64'h2030);
      step();

      // two loads, completions routed back in order
      put(1, 32'h40, 32'h0, 3'd2, 1'b1);
      step(); peek();
      chk("t3_load1_issue", 64'(bus.lsq_load), 64'h1);
      chk("t3_load1_addr", 64'(bus.lsq_addr), 64'h40);
      put(3, 32'h80, 32'h0, 3'd2, 1'b1);
      step(); peek();
      chk("t3_load3_issue", 64'(bus.lsq_load), 64'h1);
      chk("t3_load3_addr", 64'(bus.lsq_addr), 64'h80);
      step();
      bus.lsq_load_complete = 1'b1;
      bus.lsq_load_data     = 32'h11;
      peek();
      chk("t3_no_early_pulse", 64'(bus.slot_load_complete), 64'h0);
      step();
      bus.lsq_load_complete = 1'b1;
      bus.lsq_load_data     = 32'h22;
      peek();
      chk("t3_pulse_slot1", 64'(bus.slot_load_complete), 64'h2);
      chk("t3_data_slot1", 64'(bus.slot_load_data[1]), 64'h11);
      step(); peek();
      chk("t3_pulse_slot3", 64'(bus.slot_load_complete), 64'h8);
      chk("t3_data_slot3", 64'(bus.slot_load_data[3]), 64'h22);
      chk("t3_data_slot1_kept", 64'(bus.slot_load_data[1]), 64'h11);
      step(); peek();
      chk("t3_pulse_gone", 64'(bus.slot_load_complete), 64'h0);

      // LSQ backpressure for 5 cycles; a strobe while full is ignored
      bus.lsq_full = 1'b1;
      put(0, 32'h200, 32'h55, 3'd2, 1'b0);
      peek();
      chk("t4_full_at_strobe", 64'(bus.slot_lsq_full[0]), 64'h0);
      step();
      for (int j = 0; j < 5; j++) begin
         peek();
         chk("t4_hold_full", 64'(bus.slot_lsq_full[0]), 64'h1);
         chk("t4_no_issue", 64'(bus.lsq_new_request), 64'h0);
         if (j == 1) put(0, 32'hBAD, 32'h0, 3'd0, 1'b1);
         step();
      end
      bus.lsq_full = 1'b0;
      peek();
      chk("t4_issue_on_drop", 64'(bus.lsq_new_request), 64'h1);
      chk("t4_addr_kept", 64'(bus.lsq_addr), 64'h200);
      chk("t4_store_kept", 64'(bus.lsq_store), 64'h1);
      chk("t4_full_released", 64'(bus.slot_lsq_full[0]), 64'h0);
      step();

      // fill the tag FIFO with 8 back-to-back loads from slot 0
      for (int j = 0; j < ML; j++) begin
         put(0, 32'h300 + 32'(4 * j), 32'h0, 3'd2, 1'b1);
         step();
      end
      peek();
      chk("t5_last_load_addr", 64'(bus.lsq_addr), 64'h31C);
      chk("t5_b2b_full0", 64'(bus.slot_lsq_full[0]), 64'h0);
      step();
      put(2, 32'h400, 32'h0, 3'd2, 1'b1);
      put(3, 32'h500, 32'h77, 3'd2, 1'b0);
      step(); peek();
      chk("t5_store_passes", 64'(bus.lsq_store), 64'h1);
      chk("t5_store_addr", 64'(bus.lsq_addr), 64'h500);
      chk("t5_load_blocked", 64'(bus.slot_lsq_full[2]), 64'h1);
      step(); peek();
      chk("t5_still_blocked", 64'(bus.lsq_new_request), 64'h0);
      bus.lsq_load_complete = 1'b1;
      bus.lsq_load_data     = 32'h99;
      peek();
      chk("t5_pop_cycle_no_issue", 64'(bus.lsq_new_request), 64'h0);
      step(); peek();
      chk("t5_load_issue", 64'(bus.lsq_load), 64'h1);
      chk("t5_load_addr", 64'(bus.lsq_addr), 64'h400);
      chk("t5_pulse_slot0", 64'(bus.slot_load_complete), 64'h1);
      chk("t5_data_slot0", 64'(bus.slot_load_data[0]), 64'h99);
      step();

      // drain to 4 outstanding tags, park 3 holds, then reset
      for (int j = 0; j < 4; j++) begin
         bus.lsq_load_complete = 1'b1;
         bus.lsq_load_data     = 32'h60 + 32'(j);
         step();
      end
      bus.lsq_full = 1'b1;
      put(0, 32'h600, 32'h0, 3'd2, 1'b0);
      put(1, 32'h610, 32'h0, 3'd2, 1'b0);
      put(3, 32'h630, 32'h0, 3'd2, 1'b0);
      step(); peek();
      chk("t6_holds_parked", 64'(bus.slot_lsq_full), 64'hB);
      rst = 1'b1;
      step();
      rst                   = 1'b0;
      bus.lsq_full          = 1'b0;
      bus.lsq_load_complete = 1'b1;
      bus.lsq_load_data     = 32'hEE;
      peek();
      chk("t6_full_cleared", 64'(bus.slot_lsq_full), 64'h0);
      chk("t6_no_issue", 64'(bus.lsq_new_request), 64'h0);
      step(); peek();
      chk("t6_stray_no_pulse", 64'(bus.slot_load_complete), 64'h0);
      chk("t6_data_cleared", 64'(bus.slot_load_data[0]), 64'h0);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
